gray_rx_decode: RTL and testbench

Receiving stage directly downstream of the binary-to-Gray encoder. It samples the encoder's Gray-coded output, which may originate in another clock domain. It passes the value through a multi-flop synchronizer and decodes it back to binary. It then checks that each change is a legal +1 step (modulo 2^MSB) and reports a pulse per new value plus error status for the consumer logic.

---
 rtl/gray_pkg.sv | 28 ++
 rtl/gray_sync.sv | 30 +++
 rtl/gray_rx_decode.sv | 124 ++++++++++++
 tb/tb_gray_rx_decode.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types and Gray/binary conversion helpers for the Gray receiver
package gray_pkg;

  // Widest bus the conversion helpers handle. Callers zero-extend into this
  // width and keep the low bits, which is exact for both directions.
  localparam int GRAY_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } rx_state_t;

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-flop bus synchronizer for a Gray-coded input
module gray_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_q [STAGES];

  // Shift chain; the first flop is the only one that sees the asynchronous bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gray_rx_decode.sv
// rtl/gray_rx_decode.sv - synchronizes, decodes and step-checks a Gray-coded counter value
module gray_rx_decode
  import gray_pkg::*;
#(
  parameter int MSB         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_clr_err,
  input  logic [MSB-1:0]       i_gray,
  output logic                 o_valid,
  output logic [MSB-1:0]       o_bin,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic                 o_locked
);

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

  rx_state_t                    state;
  logic [MSB-1:0]               sync_gray;
  logic [MSB-1:0]               dec_next;
  logic [GRAY_MAX_W-MSB-1:0]    dec_hi_unused;
  logic [MSB-1:0]               dec_q;
  logic [MSB-1:0]               prev_q;
  logic [MSB-1:0]               delta;
  logic                         changed;
  logic                         err_hit;

  gray_sync #(
    .W      (MSB),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_gray),
    .q   (sync_gray)
  );

  // Upper bits of the widened decode are always zero and are dropped.
  assign {dec_hi_unused, dec_next} = gray2bin(GRAY_MAX_W'(sync_gray));

  // Decode register: one stage between the synchronizer and the compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q <= '0;
    end else begin
      dec_q <= dec_next;
    end
  end

  // Step check: a legal step is exactly +1 with natural wrap in MSB bits.
  assign delta   = dec_q - prev_q;
  assign changed = (dec_q != prev_q);
  assign err_hit = (state == ST_TRACK) && i_en && changed && (delta != MSB'(1));

  // Receiver FSM with registered valid/err/locked and the delivered value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
      o_locked <= 1'b0;
      o_bin    <= '0;
      prev_q   <= '0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_locked <= 1'b0;
          if (i_en) begin
            state <= ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          prev_q  <= dec_q;
          o_bin   <= dec_q;
          o_valid <= 1'b1;
          if (i_en) begin
            state    <= ST_TRACK;
            o_locked <= 1'b1;
          end else begin
            state    <= ST_IDLE;
            o_locked <= 1'b0;
          end
        end
        ST_TRACK: begin
          if (!i_en) begin
            state    <= ST_IDLE;
            o_locked <= 1'b0;
          end else begin
            o_locked <= 1'b1;
            if (changed) begin
              prev_q  <= dec_q;
              o_bin   <= dec_q;
              o_valid <= 1'b1;
              o_err   <= err_hit;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          o_locked <= 1'b0;
        end
      endcase
    end
  end

  // Saturating error counter; clear wins over a simultaneous error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_err_cnt <= '0;
    end else if (i_clr_err) begin
      o_err_cnt <= '0;
    end else if (err_hit && (o_err_cnt != ERR_CNT_MAX)) begin
      o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_rx_decode.sv
// tb/tb_gray_rx_decode.sv - self-checking bench for gray_rx_decode with a behavioural model
module tb_gray_rx_decode;

  localparam int MSB   = 4;
  localparam int S     = 2;
  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_en = 1'b0;
  logic             i_clr_err = 1'b0;
  logic [MSB-1:0]   i_gray = '0;
  logic             o_valid;
  logic [MSB-1:0]   o_bin;
  logic             o_err;
  logic [ERR_W-1:0] o_err_cnt;
  logic             o_locked;

  int checks = 0;
  int errors = 0;

  gray_rx_decode #(
    .MSB         (MSB),
    .SYNC_STAGES (S),
    .ERR_CNT_W   (ERR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_en      (i_en),
    .i_clr_err (i_clr_err),
    .i_gray    (i_gray),
    .o_valid   (o_valid),
    .o_bin     (o_bin),
    .o_err     (o_err),
    .o_err_cnt (o_err_cnt),
    .o_locked  (o_locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Gray decode by search: the binary value whose Gray code equals g.
  function automatic int g2b(input int g);
    for (int b = 0; b < (1 << MSB); b++) begin
      if (((b ^ (b >> 1)) & ((1 << MSB) - 1)) == g) return b;
    end
    return -1;
  endfunction

  function automatic logic [MSB-1:0] b2g(input int b);
    int bb;
    bb = b & ((1 << MSB) - 1);
    return MSB'(bb ^ (bb >> 1));
  endfunction

  // Model: 0 idle, 1 acquire, 2 track
  int          m_mode = 0;
  int          m_bin = 0;
  int          m_valid = 0;
  int          m_err = 0;
  int          m_cnt = 0;
  int          m_locked = 0;
  int          hist[$] = '{0, 0, 0};

  always @(posedge clk or posedge rst) begin
    int val;
    int nv;
    int ne;
    if (rst) begin
      m_mode = 0; m_bin = 0; m_valid = 0; m_err = 0; m_cnt = 0; m_locked = 0;
      hist = {};
      repeat (S + 1) hist.push_back(0);
    end else begin
      // value seen by the output stage is the input sampled S+1 edges earlier
      val = g2b(hist[S]);
      hist.push_front(int'(i_gray));
      void'(hist.pop_back());
      nv = 0;
      ne = 0;
      case (m_mode)
        0: if (i_en) m_mode = 1;
        1: begin
          m_bin = val;
          nv = 1;
          m_mode = i_en ? 2 : 0;
        end
        default: begin
          if (!i_en) m_mode = 0;
          else if (val != m_bin) begin
            nv = 1;
            ne = (((val - m_bin + (1 << MSB)) % (1 << MSB)) != 1) ? 1 : 0;
            m_bin = val;
          end
        end
      endcase
      m_valid = nv;
      m_err = ne;
      if (i_clr_err) m_cnt = 0;
      else if (ne == 1 && m_cnt < (1 << ERR_W) - 1) m_cnt++;
      m_locked = (m_mode == 2) ? 1 : 0;
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("valid", int'(o_valid), m_valid);
    check("bin", int'(o_bin), m_bin);
    check("err", int'(o_err), m_err);
    check("err_cnt", int'(o_err_cnt), m_cnt);
    check("locked", int'(o_locked), m_locked);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [MSB-1:0] cur_g;
    int cur_b;
    @(negedge clk);
    tick(3);
    rst = 1'b0;

    // 1: idle with legal toggling, receiver disabled
    for (int k = 1; k <= 6; k++) begin
      i_gray = b2g(k);
      tick(5);
    end
    check("idle_valid", int'(o_valid), 0);
    check("idle_locked", int'(o_locked), 0);
    check("idle_bin", int'(o_bin), 0);

    // 2: acquire bin 4
    i_gray = 4'b0110;
    tick(6);
    i_en = 1'b1;
    tick(2);
    check("acq_valid", int'(o_valid), 1);
    check("acq_bin", int'(o_bin), 4);
    check("acq_err", int'(o_err), 0);
    tick(1);
    check("acq_single_pulse", int'(o_valid), 0);
    check("acq_locked", int'(o_locked), 1);

    // 3: counting 0 -> 1 -> 2 -> 3
    i_gray = 4'b0000;
    tick(9);
    i_gray = 4'b0001; tick(4);
    check("cnt1_valid", int'(o_valid), 1);
    check("cnt1_bin", int'(o_bin), 1);
    check("cnt1_err", int'(o_err), 0);
    tick(5);
    i_gray = 4'b0011; tick(4);
    check("cnt2_bin", int'(o_bin), 2);
    check("cnt2_err", int'(o_err), 0);
    tick(5);
    i_gray = 4'b0010; tick(4);
    check("cnt3_bin", int'(o_bin), 3);
    check("cnt3_err", int'(o_err), 0);
    tick(5);

    // 4: wrap 15 -> 0
    i_gray = 4'b1010; tick(9);
    i_gray = 4'b1000; tick(9);
    check("at15_bin", int'(o_bin), 15);
    i_gray = 4'b0000; tick(4);
    check("wrap_valid", int'(o_valid), 1);
    check("wrap_bin", int'(o_bin), 0);
    check("wrap_err", int'(o_err), 0);
    tick(5);

    // 5: error 3 -> 5 with counter freshly cleared, then saturation
    i_gray = 4'b0010; tick(9);
    i_clr_err = 1'b1; tick(1);
    i_clr_err = 1'b0;
    check("cleared_cnt", int'(o_err_cnt), 0);
    i_gray = 4'b0111; tick(4);
    check("step_err", int'(o_err), 1);
    check("step_bin", int'(o_bin), 5);
    check("step_cnt", int'(o_err_cnt), 1);
    tick(1);
    for (int k = 0; k < 300; k++) begin
      i_gray = (k % 2 == 0) ? 4'b1111 : 4'b0111;
      tick(5);
    end
    check("sat_cnt", int'(o_err_cnt), 255);
    i_gray = 4'b1111; tick(4);
    check("sat_err_pulse", int'(o_err), 1);
    check("sat_hold", int'(o_err_cnt), 255);
    tick(1);

    // 6: clear coincident with an error
    i_gray = 4'b0111; tick(3);
    i_clr_err = 1'b1; tick(1);
    check("clr_err_pulse", int'(o_err), 1);
    check("clr_cnt", int'(o_err_cnt), 0);
    i_clr_err = 1'b0;
    tick(2);

    // async reset mid-TRACK
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_valid", int'(o_valid), 0);
    check("rst_bin", int'(o_bin), 0);
    check("rst_err", int'(o_err), 0);
    check("rst_cnt", int'(o_err_cnt), 0);
    check("rst_locked", int'(o_locked), 0);
    @(negedge clk);
    i_en = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(6);
    i_en = 1'b1;
    tick(2);
    check("reacq_valid", int'(o_valid), 1);
    check("reacq_bin", int'(o_bin), 5);
    tick(1);
    check("reacq_locked", int'(o_locked), 1);

    // 7: randomized walk, mostly legal steps, with enable drops and clears
    cur_g = i_gray;
    cur_b = g2b(int'(cur_g));
    for (int seg = 0; seg < 160; seg++) begin
      if ($urandom_range(0, 3) != 0) begin
        cur_b = (cur_b + 1) % (1 << MSB);
        cur_g = b2g(cur_b);
      end else begin
        cur_g = cur_g ^ MSB'(1 << $urandom_range(0, MSB - 1));
        cur_b = g2b(int'(cur_g));
      end
      i_gray = cur_g;
      if ($urandom_range(0, 9) == 0) i_en = ~i_en;
      else if (!i_en && $urandom_range(0, 1) == 0) i_en = 1'b1;
      i_clr_err = ($urandom_range(0, 11) == 0);
      tick(1);
      i_clr_err = 1'b0;
      tick($urandom_range(3, 9));
    end
    tick(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
